// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - sprite DMA engine: halts the CPU and copies one page into OAMDATA
module oam_dma_controller #(
    parameter logic [15:0] REG_ADDRESS     = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDRESS = 16'h2004,
    parameter int          TRANSFER_LENGTH = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_address,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_cpu_data,
    input  logic [7:0]  i_data,
    output logic        o_rdy,
    output logic        o_dma_active,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    output logic        o_busy,
    output logic [7:0]  o_debug_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    // Index of the final byte; the index register never advances past it.
    localparam logic [7:0] LAST_INDEX = 8'(TRANSFER_LENGTH - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] index;
    logic [7:0] page;
    logic [7:0] latch;
    logic       phase;
    logic       trigger;

    // A CPU write to the DMA register; reads of the same address are harmless.
    assign trigger       = !i_cpu_rw && (i_cpu_address == REG_ADDRESS);
    assign o_debug_index = index;

    // State register; reset aborts any transfer in progress and releases RDY.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: get/put phase toggle, page capture, byte latch and index advance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase <= 1'b0;
            index <= 8'd0;
            page  <= 8'd0;
            latch <= 8'd0;
        end else begin
            phase <= ~phase;
            if (state == S_IDLE && trigger) begin
                page  <= i_cpu_data;
                index <= 8'd0;
            end
            if (state == S_READ) begin
                latch <= i_data;
            end
            if (state == S_WRITE && index != LAST_INDEX) begin
                index <= index + 8'd1;
            end
        end
    end

    // Next-state and Moore outputs; HALT leaves on a CPU read, aligning READ to a get cycle.
    always_comb begin
        next_state   = state;
        o_rdy        = 1'b1;
        o_busy       = 1'b0;
        o_dma_active = 1'b0;
        o_address    = 16'h0000;
        o_rw         = 1'b1;
        o_data       = 8'h00;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    next_state = S_HALT;
                end
            end
            S_HALT: begin
                o_rdy  = 1'b0;
                o_busy = 1'b1;
                if (i_cpu_rw) begin
                    next_state = phase ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: begin
                o_rdy      = 1'b0;
                o_busy     = 1'b1;
                next_state = S_READ;
            end
            S_READ: begin
                o_rdy        = 1'b0;
                o_busy       = 1'b1;
                o_dma_active = 1'b1;
                o_address    = {page, index};
                o_rw         = 1'b1;
                next_state   = S_WRITE;
            end
            S_WRITE: begin
                o_rdy        = 1'b0;
                o_busy       = 1'b1;
                o_dma_active = 1'b1;
                o_address    = OAMDATA_ADDRESS;
                o_rw         = 1'b0;
                o_data       = latch;
                next_state   = (index == LAST_INDEX) ? S_IDLE : S_READ;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - directed self-checking bench for oam_dma_controller
module tb_oam_dma_controller;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_address;
    logic        cpu_rw;
    logic [7:0]  cpu_data;
    logic [7:0]  sys_data;
    logic        o_rdy;
    logic        o_dma_active;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
    logic        o_busy;
    logic [7:0]  o_debug_index;

    int errors = 0;
    int checks = 0;

    // Bench-side phase model: cycles since reset, parity equals the get/put phase.
    int cyc;

    // Transfer observation results.
    int          halted, reads, writes, passive;
    int          addr_err, data_err, phase_err, busy_err, order_err, idx_err;
    bit          timed_out, reset_hit;
    logic        trig_act;
    logic [15:0] first_raddr, last_waddr;
    logic [7:0]  last_idx;
    logic        rdy_after, act_after, busy_after;
    logic        rst_rdy, rst_act, rst_busy;
    logic [7:0]  rst_idx;

    oam_dma_controller dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_cpu_address (cpu_address),
        .i_cpu_rw      (cpu_rw),
        .i_cpu_data    (cpu_data),
        .i_data        (sys_data),
        .o_rdy         (o_rdy),
        .o_dma_active  (o_dma_active),
        .o_address     (o_address),
        .o_rw          (o_rw),
        .o_data        (o_data),
        .o_busy        (o_busy),
        .o_debug_index (o_debug_index)
    );

    // RAM model: page $02 holds i^A5, other pages differ by the page number.
    assign sys_data = o_address[7:0] ^ o_address[15:8] ^ 8'hA7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Trigger a transfer on the requested phase and watch every halted cycle.
    task automatic xfer(input logic [7:0] page, input logic want_odd, input int rmw,
                        input bit mid_write, input bit do_reset);
        int k;
        k = 0;
        halted = 0; reads = 0; writes = 0; passive = 0;
        addr_err = 0; data_err = 0; phase_err = 0; busy_err = 0; order_err = 0; idx_err = 0;
        timed_out = 1; reset_hit = 0;
        first_raddr = 16'hxxxx; last_waddr = 16'hxxxx; last_idx = 8'hxx;
        while (cyc[0] !== want_odd) step();
        cpu_address = 16'h4014; cpu_rw = 1'b0; cpu_data = page;
        trig_act = o_dma_active;
        step();
        for (int c = 0; c < 1200; c++) begin
            cpu_data = 8'h00;
            if (c < rmw) begin cpu_address = 16'h0010; cpu_rw = 1'b0; end
            else         begin cpu_address = 16'h8000; cpu_rw = 1'b1; end
            if (mid_write && k == 50 && writes == 50 && reads == 50) begin
                cpu_address = 16'h4014; cpu_rw = 1'b0; cpu_data = 8'h07;
            end
            if (do_reset && k == 100) begin
                #3 rst = 1'b1;
                #1 rst_rdy = o_rdy; rst_act = o_dma_active; rst_busy = o_busy; rst_idx = o_debug_index;
                #1 rst = 1'b0;
                reset_hit = 1; timed_out = 0;
                cpu_address = 16'h8000; cpu_rw = 1'b1;
                break;
            end
            if (o_rdy === 1'b1) begin timed_out = 0; break; end
            halted++;
            if (o_busy !== 1'b1) busy_err++;
            if (o_dma_active === 1'b1) begin
                if (o_rw === 1'b1) begin
                    if (reads != writes) order_err++;
                    reads++;
                    if (reads == 1) first_raddr = o_address;
                    if (o_address !== {page, 8'(k)}) addr_err++;
                    if (cyc[0] !== 1'b0) phase_err++;
                end else begin
                    if (reads != writes + 1) order_err++;
                    writes++;
                    if (o_address !== 16'h2004) addr_err++;
                    if (o_data !== (8'(k) ^ page ^ 8'hA7)) data_err++;
                    if (o_debug_index !== 8'(k)) idx_err++;
                    if (cyc[0] !== 1'b1) phase_err++;
                    last_idx = o_debug_index; last_waddr = o_address;
                    k++;
                end
            end else begin
                passive++;
                if (reads > 0) order_err++;
            end
            step();
        end
        rdy_after = o_rdy; act_after = o_dma_active; busy_after = o_busy;
        cpu_address = 16'h8000; cpu_rw = 1'b1; cpu_data = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_address = 16'h8000; cpu_rw = 1'b1; cpu_data = 8'h00;
        #2;
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", o_rdy); end
        checks++; if (o_dma_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", o_dma_active); end
        checks++; if (o_address !== 16'h0000) begin errors++; $display("FAIL reset_address: got %h want 0000", o_address); end
        checks++; if (o_rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b want 1", o_rw); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_debug_index !== 8'h00) begin errors++; $display("FAIL reset_index: got %h want 00", o_debug_index); end
        @(posedge clk); #1 rst = 1'b0;
        step();
    endtask

    task automatic test_no_trigger();
        int busy_seen;
        busy_seen = 0;
        for (int c = 0; c < 4; c++) begin
            cpu_address = 16'h4014; cpu_rw = 1'b1; cpu_data = 8'h09;
            if (c == 2) begin cpu_address = 16'h4015; cpu_rw = 1'b0; end
            step();
            if (o_busy !== 1'b0 || o_rdy !== 1'b1) busy_seen++;
        end
        cpu_address = 16'h8000; cpu_rw = 1'b1; cpu_data = 8'h00;
        step();
        if (o_busy !== 1'b0) busy_seen++;
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL read_no_trigger: busy cycles %0d want 0", busy_seen); end
    endtask

    task automatic test_even_phase();
        xfer(8'h02, 1'b0, 0, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL even_timeout: transfer did not end"); end
        checks++; if (trig_act !== 1'b0) begin errors++; $display("FAIL even_trigger_active: got %b want 0", trig_act); end
        checks++; if (halted !== 513) begin errors++; $display("FAIL even_halted: got %0d want 513", halted); end
        checks++; if (passive !== 1) begin errors++; $display("FAIL even_idle_cycles: got %0d want 1", passive); end
        checks++; if (reads !== 256 || writes !== 256) begin errors++; $display("FAIL even_count: reads %0d writes %0d want 256", reads, writes); end
        checks++; if (addr_err + data_err + idx_err !== 0) begin errors++; $display("FAIL even_data: addr %0d data %0d idx %0d errors want 0", addr_err, data_err, idx_err); end
        checks++; if (phase_err + order_err + busy_err !== 0) begin errors++; $display("FAIL even_order: phase %0d order %0d busy %0d errors want 0", phase_err, order_err, busy_err); end
        checks++; if (busy_after !== 1'b0 || rdy_after !== 1'b1) begin errors++; $display("FAIL even_release: busy %b rdy %b want 0/1", busy_after, rdy_after); end
    endtask

    task automatic test_odd_phase();
        xfer(8'h02, 1'b1, 0, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL odd_timeout: transfer did not end"); end
        checks++; if (halted !== 514) begin errors++; $display("FAIL odd_halted: got %0d want 514", halted); end
        checks++; if (passive !== 2) begin errors++; $display("FAIL odd_align: idle cycles %0d want 2", passive); end
        checks++; if (first_raddr !== 16'h0200) begin errors++; $display("FAIL odd_first_read: got %h want 0200", first_raddr); end
        checks++; if (phase_err + addr_err + data_err + order_err !== 0) begin errors++; $display("FAIL odd_sequence: phase %0d addr %0d data %0d order %0d want 0", phase_err, addr_err, data_err, order_err); end
    endtask

    task automatic test_rmw_halt();
        xfer(8'h02, 1'b0, 2, 0, 0);
        checks++; if (halted !== 515) begin errors++; $display("FAIL rmw_halted: got %0d want 515", halted); end
        checks++; if (passive !== 3) begin errors++; $display("FAIL rmw_idle_cycles: got %0d want 3", passive); end
        checks++; if (order_err + addr_err + data_err !== 0) begin errors++; $display("FAIL rmw_sequence: order %0d addr %0d data %0d want 0", order_err, addr_err, data_err); end
    endtask

    task automatic test_busy_write_ignored();
        xfer(8'h03, 1'b0, 0, 1, 0);
        checks++; if (halted !== 513) begin errors++; $display("FAIL busy_write_halted: got %0d want 513", halted); end
        checks++; if (addr_err + data_err !== 0) begin errors++; $display("FAIL busy_write_page: addr %0d data %0d errors want 0", addr_err, data_err); end
        checks++; if (reads !== 256) begin errors++; $display("FAIL busy_write_reads: got %0d want 256", reads); end
    endtask

    task automatic test_mid_reset();
        xfer(8'h02, 1'b0, 0, 0, 1);
        checks++; if (reset_hit !== 1'b1) begin errors++; $display("FAIL mid_reset_reached: got %b want 1", reset_hit); end
        checks++; if (rst_rdy !== 1'b1 || rst_act !== 1'b0 || rst_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: rdy %b active %b busy %b want 1/0/0", rst_rdy, rst_act, rst_busy); end
        checks++; if (rst_idx !== 8'h00) begin errors++; $display("FAIL mid_reset_index: got %h want 00", rst_idx); end
        checks++; if (writes !== 100) begin errors++; $display("FAIL mid_reset_writes: got %0d want 100", writes); end
        xfer(8'h02, 1'b0, 0, 0, 0);
        checks++; if (first_raddr !== 16'h0200) begin errors++; $display("FAIL restart_first_read: got %h want 0200", first_raddr); end
        checks++; if (halted !== 513 || reads !== 256 || addr_err + data_err !== 0) begin errors++; $display("FAIL restart_transfer: halted %0d reads %0d addr %0d data %0d want 513/256/0/0", halted, reads, addr_err, data_err); end
    endtask

    task automatic test_last_byte();
        int act_seen;
        act_seen = 0;
        xfer(8'h05, 1'b1, 0, 0, 0);
        checks++; if (last_idx !== 8'hFF) begin errors++; $display("FAIL last_index: got %h want ff", last_idx); end
        checks++; if (last_waddr !== 16'h2004) begin errors++; $display("FAIL last_address: got %h want 2004", last_waddr); end
        checks++; if (rdy_after !== 1'b1 || act_after !== 1'b0) begin errors++; $display("FAIL last_release: rdy %b active %b want 1/0", rdy_after, act_after); end
        checks++; if (reads !== 256 || addr_err !== 0) begin errors++; $display("FAIL last_reads: got %0d reads %0d addr errors want 256/0", reads, addr_err); end
        for (int c = 0; c < 4; c++) begin
            if (o_dma_active !== 1'b0 || o_address === 16'h0600) act_seen++;
            step();
        end
        checks++; if (act_seen !== 0) begin errors++; $display("FAIL last_no_overrun: active cycles %0d want 0", act_seen); end
    endtask

    initial begin
        test_reset();
        test_no_trigger();
        test_even_phase();
        test_odd_phase();
        test_rmw_halt();
        test_busy_write_ignored();
        test_mid_reset();
        test_last_byte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
